// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation and state
// encodings, iteration count and small operation-decoding helpers.
package mdu_pkg;

  localparam int ITERATIONS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One iteration of unsigned restoring division: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module mdu_div_step (
  input  logic [31:0] rem,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // The remainder stays below the divisor, so the shifted value fits in 33 bits.
  assign shifted  = {rem, dividend_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up at completion.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state, state_nxt;
  logic [4:0]  cnt;
  op_e         op_q;
  logic [31:0] acc;      // product high half / partial remainder
  logic [31:0] low;      // multiplier -> product low half / dividend -> quotient
  logic [31:0] b_mag;
  logic        neg_res;
  logic        neg_rem;
  logic        b_zero;

  logic        accept;
  logic        last;

  assign accept = (state != RUN) && start && !flush;
  assign last   = (state == RUN) && (cnt == 5'(ITERATIONS - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand magnitudes and result signs, evaluated on the launch cycle.
  logic        in_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag_in;

  assign in_signed = op_is_signed(op_e'(op));
  assign a_neg     = in_signed && src_a[31];
  assign b_neg     = in_signed && src_b[31];
  assign a_mag     = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag_in  = b_neg ? (~src_b + 32'd1) : src_b;

  // Multiply step: conditionally add the multiplicand, then shift the pair right.
  logic [32:0] mul_sum;
  logic [31:0] mul_acc_nxt, mul_low_nxt;

  assign mul_sum     = {1'b0, acc} + (low[0] ? {1'b0, b_mag} : 33'd0);
  assign mul_acc_nxt = mul_sum[32:1];
  assign mul_low_nxt = {mul_sum[0], low[31:1]};

  logic [31:0] div_rem_nxt, div_low_nxt;
  logic        div_q_bit;

  mdu_div_step u_div_step (
    .rem          (acc),
    .dividend_bit (low[31]),
    .divisor      (b_mag),
    .rem_next     (div_rem_nxt),
    .q_bit        (div_q_bit)
  );

  assign div_low_nxt = {low[30:0], div_q_bit};

  logic        is_div;
  logic [31:0] acc_nxt, low_nxt;

  assign is_div  = op_is_div(op_q);
  assign acc_nxt = is_div ? div_rem_nxt : mul_acc_nxt;
  assign low_nxt = is_div ? div_low_nxt : mul_low_nxt;

  // Final results are formed from the last iteration's outputs so hi/lo load on that same edge.
  // A zero divisor yields remainder = dividend naturally; only the quotient needs forcing.
  logic [63:0] prod, prod_s;
  logic [31:0] quo_s, rem_s;
  logic [31:0] res_hi, res_lo;

  assign prod   = {acc_nxt, low_nxt};
  assign prod_s = neg_res ? (~prod + 64'd1) : prod;
  assign quo_s  = neg_res ? (~low_nxt + 32'd1) : low_nxt;
  assign rem_s  = neg_rem ? (~acc_nxt + 32'd1) : acc_nxt;
  assign res_hi = is_div ? rem_s : prod_s[63:32];
  assign res_lo = is_div ? (b_zero ? 32'hFFFF_FFFF : quo_s) : prod_s[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= OP_MULT;
      acc     <= '0;
      low     <= '0;
      b_mag   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (state != RUN || flush) cnt <= '0;
      else                       cnt <= cnt + 5'd1;

      if (accept) begin
        op_q    <= op_e'(op);
        acc     <= '0;
        low     <= a_mag;
        b_mag   <= b_mag_in;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        b_zero  <= (src_b == 32'd0);
      end else if (state == RUN) begin
        acc <= acc_nxt;
        low <= low_nxt;
      end

      if (last && !flush) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state != RUN) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  mul_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (o)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Counts posedges after the launch edge until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    logic [63:0] exp;
    exp = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom; src_b = $urandom; op = 2'($urandom);
    check({tag, "_busy"}, busy, 1);
    wait_done(lat);
    check({tag, "_latency"}, lat, 32);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int          lat;
    logic [31:0] lo_saved;

    rst = 1'b1;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", lo, 32'h0000_0001);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0005);
    check("mult_neg_lo_const", lo, 32'hFFFF_FFF1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; op = 2'd1; src_a = 32'hABCD_1234; src_b = 32'h9876_5432;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("multu_2x3", 2'd1, 32'd2, 32'd3);
    check("multu_2x3_lo_const", lo, 32'd6);

    run_op("div_neg7", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_lo_const", lo, 32'hFFFF_FFFD);
    run_op("divu_by0", 2'd3, 32'd7, 32'd0);
    check("divu_by0_hi_const", hi, 32'd7);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    run_op("div_neg_by0", 2'd2, 32'h8000_0003, 32'd0);

    // MTHI, then hi_we ignored while busy, then flush.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'h1234_5678);
    lo_saved = lo;
    start = 1'b1; op = 2'd1; src_a = 32'd5; src_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    hi_we = 1'b0;
    check("hi_we_busy_ignored", hi, 32'h1234_5678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_hi", hi, 32'h1234_5678);
    check("flush_lo", lo, lo_saved);
    @(posedge clk);
    @(negedge clk);
    check("flush_no_done_later", done, 0);

    // Register writes together with an accepted start, then overwritten by the result.
    start = 1'b1; op = 2'd3; src_a = 32'd100; src_b = 32'd7;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("wr_start_hi", hi, 32'hA5A5_A5A5);
    check("wr_start_lo", lo, 32'hA5A5_A5A5);
    wait_done(lat);
    check("wr_start_latency", lat, 32);
    check("wr_start_res_hi", hi, 32'd2);
    check("wr_start_res_lo", lo, 32'd14);
    @(posedge clk);
    @(negedge clk);

    // Back-to-back: start held high so the second operation launches from DONE.
    start = 1'b1; op = 2'd1; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    op = 2'd3; src_a = 32'd1000; src_b = 32'd9;
    wait_done(lat);
    check("b2b_first_latency", lat, 32);
    check("b2b_gap_busy", busy, 0);
    check("b2b_first_lo", lo, 32'd42);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", busy, 1);
    check("b2b_second_no_done", done, 0);
    wait_done(lat);
    check("b2b_second_latency", lat, 32);
    check("b2b_second_hi", hi, 32'd1);
    check("b2b_second_lo", lo, 32'd111);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port rst, input, 1: reset, asynchronous, active-high.
REQ-003 Port start, input, 1: launch operation; sampled on rising clk.
REQ-004 Port op, input, 2: operation select; 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-005 Port src_a, input, 32: rs operand (regfile readData1); multiplicand or dividend.
REQ-006 Port src_b, input, 32: rt operand (regfile readData2); multiplier or divisor.
REQ-007 Port hi_we, input, 1: MTHI write strobe.
REQ-008 Port lo_we, input, 1: MTLO write strobe.
REQ-009 Port wdata, input, 32: data for hi_we/lo_we.
REQ-010 Port flush, input, 1: abort in-flight operation (exception/cancel).
REQ-011 Port busy, output, 1: operation in progress; pipeline stalls MFHI/MFLO/new start while high.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port hi, output, 32: HI register.
REQ-014 Port lo, output, 32: LO register.

Function
REQ-015 States IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-016 IDLE or DONE with start=1 and flush=0 -> RUN; op, src_a, src_b captured at that edge; later operand changes have no effect.
REQ-017 start while busy is ignored.
REQ-018 RUN executes exactly 32 single-bit iterations (shift-add multiply, restoring divide), one per cycle, 5-bit counter 0..31.
REQ-019 On the 32nd RUN edge, hi/lo are loaded with the result and state -> DONE; DONE lasts one cycle, then -> IDLE unless a new start is accepted.
REQ-020 Latency: start sampled at edge E0; busy high for cycles E0..E32; hi/lo updated at E32; done high for the cycle E32..E33.
REQ-021 MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned per op.
REQ-022 DIV/DIVU: lo = quotient, hi = remainder; signed form operates on magnitudes, quotient negated if operand signs differ, remainder takes the dividend's sign.
REQ-023 Divisor zero (DIV or DIVU): lo = 0xFFFFFFFF, hi = captured src_a.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-025 hi_we/lo_we honoured only when busy=0 (writes hi/lo from wdata next edge); ignored while busy.
REQ-026 hi_we/lo_we together with an accepted start: the write is applied at that edge; the result overwrites it at completion.
REQ-027 flush in RUN: -> IDLE next edge, hi/lo unchanged, no done pulse; flush with start in IDLE/DONE: start rejected.
REQ-028 hi/lo change only via REQ-019, REQ-025 or reset.

Reset
REQ-029 rst asserted at any time, including mid-RUN: state = IDLE, counter = 0, hi = lo = 0, busy = done = 0 immediately (asynchronous).
REQ-030 First start honoured at the first rising edge after rst deasserts.

Structure
REQ-031 Shared package mdu_pkg holds op encodings, state encoding and the iteration count constant (32).
REQ-032 One sub-module, mdu_div_step: combinational one-bit restoring-division step (partial remainder, divisor -> next remainder, quotient bit); multiply step stays inline.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 33 after start; hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT 0xFFFFFFFD(-3) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-035 DIV 0xFFFFFFF9(-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-036 MTHI 0x12345678, then start and flush after 10 RUN cycles -> busy low next cycle, no done, hi=0x12345678; hi_we during RUN leaves hi unchanged.
REQ-037 rst pulsed at RUN cycle 20 -> busy=0, hi=lo=0 without a clock edge; a fresh MULTU 2x3 afterwards -> lo=6, hi=0.
REQ-038 Back-to-back: start held high through DONE -> second operation accepted at E33, busy low only for the DONE cycle.
